// File: rtl/prbs_check_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_pkg
//  Description : Shared state encoding and width helper for the PRBS checker.
//  Revision    : 1.0
// ============================================================================
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CHECK   = 2'b01,
        ST_FAIL    = 2'b10,
        ST_SUCCESS = 2'b11
    } state_t;

    // Byte index width; a two-byte sequence still needs one bit.
    function automatic int bn_width(input int bytes_per_seq);
        return (bytes_per_seq <= 2) ? 1 : $clog2(bytes_per_seq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_check_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_check_ctrl_if
//  Description : Control/status bundle between the checker FSM and its user.
//  Revision    : 1.0
// ============================================================================
interface prbs_check_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8,
    parameter int BN_W  = 2
);
    logic             start;
    logic             clear;
    logic             byte_valid;
    logic             true_byte;
    logic [CNT_W-1:0] n;
    logic [ERR_W-1:0] max_err;
    logic             enable;
    logic             pattern_valid;
    logic             pattern_fail;
    logic             busy;
    logic [BN_W-1:0]  byte_num;
    logic [CNT_W-1:0] seq_num;
    logic [ERR_W-1:0] err_count;

    modport master (
        output start, clear, byte_valid, true_byte, n, max_err,
        input  enable, pattern_valid, pattern_fail, busy, byte_num, seq_num, err_count
    );

    modport slave (
        input  start, clear, byte_valid, true_byte, n, max_err,
        output enable, pattern_valid, pattern_fail, busy, byte_num, seq_num, err_count
    );
endinterface
`default_nettype wire

// File: rtl/prbs_check_ctrl_pos_counter.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_pos_counter
//  Description : Byte/sequence position pair with end-of-check detection.
//  Revision    : 1.0
// ============================================================================
module prbs_pos_counter
    import prbs_pkg::*;
#(
    parameter int BYTES_PER_SEQ = 4,
    parameter int CNT_W         = 8,
    parameter int BN_W          = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    input  wire logic             clr,
    input  wire logic [CNT_W-1:0] n_q,
    output logic      [BN_W-1:0]  byte_num,
    output logic      [CNT_W-1:0] seq_num,
    output logic                  last
);
    localparam logic [BN_W-1:0] C_BYTE_MAX = BN_W'(BYTES_PER_SEQ - 1);

    logic [BN_W-1:0]  r_byte_num;
    logic [CNT_W-1:0] r_seq_num;
    logic             w_byte_wrap;

    assign w_byte_wrap = (r_byte_num == C_BYTE_MAX);
    assign last        = w_byte_wrap && (r_seq_num == (n_q - CNT_W'(1)));
    assign byte_num    = r_byte_num;
    assign seq_num     = r_seq_num;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_num <= '0;
            r_seq_num  <= '0;
        end else if (clr) begin
            r_byte_num <= '0;
            r_seq_num  <= '0;
        end else if (inc) begin
            if (w_byte_wrap) begin
                r_byte_num <= '0;
                r_seq_num  <= r_seq_num + CNT_W'(1);
            end else begin
                r_byte_num <= r_byte_num + BN_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prbs_check_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_check_ctrl
//  Description : PRBS-15 checker control FSM with error tolerance and position.
//  Revision    : 1.0
// ============================================================================
module prbs_check_ctrl
    import prbs_pkg::*;
#(
    parameter int BYTES_PER_SEQ = 4,
    parameter int CNT_W         = 8,
    parameter int ERR_W         = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    prbs_check_ctrl_if.slave   bus
);
    localparam int BN_W = bn_width(BYTES_PER_SEQ);
    localparam logic [ERR_W-1:0] C_ERR_MAX = {ERR_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_n_q;
    logic [ERR_W-1:0] r_max_err_q;
    logic [ERR_W-1:0] r_err_count;
    logic [ERR_W-1:0] w_err_next;
    logic             w_fail;
    logic             w_last;
    logic             w_cnt_inc;
    logic             w_cnt_clr;
    logic             w_load;
    logic             w_err_upd;
    logic [BN_W-1:0]  w_byte_num;
    logic [CNT_W-1:0] w_seq_num;

    prbs_pos_counter #(
        .BYTES_PER_SEQ (BYTES_PER_SEQ),
        .CNT_W         (CNT_W),
        .BN_W          (BN_W)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_cnt_inc),
        .clr      (w_cnt_clr),
        .n_q      (r_n_q),
        .byte_num (w_byte_num),
        .seq_num  (w_seq_num),
        .last     (w_last)
    );

    // Saturating accumulate; an all-ones tolerance never fails.
    assign w_err_next = (bus.true_byte || (r_err_count == C_ERR_MAX)) ?
                        r_err_count : r_err_count + ERR_W'(1);
    assign w_fail     = !bus.true_byte && (r_max_err_q != C_ERR_MAX) &&
                        (w_err_next > r_max_err_q);

    always_comb begin
        w_state_next = r_state;
        w_cnt_inc    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_load       = 1'b0;
        w_err_upd    = 1'b0;
        if (bus.clear) begin
            w_state_next = ST_IDLE;
            w_cnt_clr    = 1'b1;
        end else begin
            case (r_state)
                ST_CHECK: begin
                    if (bus.byte_valid) begin
                        w_err_upd = 1'b1;
                        if (w_fail) begin
                            w_state_next = ST_FAIL;
                        end else if (w_last) begin
                            w_state_next = ST_SUCCESS;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.start && (bus.n != '0)) begin
                        w_state_next = ST_CHECK;
                        w_load       = 1'b1;
                        w_cnt_clr    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_n_q       <= '0;
            r_max_err_q <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_n_q       <= bus.n;
                r_max_err_q <= bus.max_err;
            end
            if (w_cnt_clr) begin
                r_err_count <= '0;
            end else if (w_err_upd) begin
                r_err_count <= w_err_next;
            end
        end
    end

    assign bus.enable        = (r_state == ST_IDLE) || (r_state == ST_CHECK);
    assign bus.busy          = (r_state == ST_CHECK);
    assign bus.pattern_valid = (r_state == ST_SUCCESS);
    assign bus.pattern_fail  = (r_state == ST_FAIL);
    assign bus.byte_num      = w_byte_num;
    assign bus.seq_num       = w_seq_num;
    assign bus.err_count     = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_prbs_check_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs_check_ctrl
//  Description : Self-checking bench for prbs_check_ctrl (model + literals).
//  Revision    : 1.0
// ============================================================================
module tb_prbs_check_ctrl;
    localparam int B = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    prbs_check_ctrl_if #(.CNT_W(8), .ERR_W(8), .BN_W(2)) bus  ();
    prbs_check_ctrl_if #(.CNT_W(8), .ERR_W(2), .BN_W(2)) bus2 ();

    prbs_check_ctrl #(.BYTES_PER_SEQ(B), .CNT_W(8), .ERR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    prbs_check_ctrl #(.BYTES_PER_SEQ(B), .CNT_W(8), .ERR_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: accepted-byte ordinal k gives position; status is a simple label.
    typedef enum int {M_IDLE, M_RUN, M_PASS, M_FAILED} mstat_t;
    mstat_t m_st;
    int     m_k, m_err, m_n, m_max;

    always @(posedge clk or posedge rst) begin
        int e2;
        if (rst) begin
            m_st <= M_IDLE; m_k <= 0; m_err <= 0; m_n <= 0; m_max <= 0;
        end else if (bus.clear) begin
            m_st <= M_IDLE; m_k <= 0; m_err <= 0;
        end else if (m_st != M_RUN) begin
            if (bus.start && bus.n != 0) begin
                m_st <= M_RUN; m_k <= 0; m_err <= 0;
                m_n <= int'(bus.n); m_max <= int'(bus.max_err);
            end
        end else if (bus.byte_valid) begin
            e2 = m_err + (bus.true_byte ? 0 : 1);
            if (e2 > 255) e2 = 255;
            m_err <= e2;
            if (!bus.true_byte && m_max != 255 && e2 > m_max) m_st <= M_FAILED;
            else if (m_k == B * m_n - 1)                      m_st <= M_PASS;
            else                                              m_k  <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        chk("enable",        32'(bus.enable),        32'(m_st == M_IDLE || m_st == M_RUN));
        chk("busy",          32'(bus.busy),          32'(m_st == M_RUN));
        chk("pattern_valid", 32'(bus.pattern_valid), 32'(m_st == M_PASS));
        chk("pattern_fail",  32'(bus.pattern_fail),  32'(m_st == M_FAILED));
        chk("byte_num",      32'(bus.byte_num),      32'(m_k % B));
        chk("seq_num",       32'(bus.seq_num),       32'(m_k / B));
        chk("err_count",     32'(bus.err_count),     32'(m_err));
    end

    task automatic step(input logic s, input logic c, input logic v, input logic t);
        @(negedge clk);
        bus.start = s; bus.clear = c; bus.byte_valid = v; bus.true_byte = t;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_start(input logic [7:0] nn, input logic [7:0] me);
        @(negedge clk);
        bus.n = nn; bus.max_err = me;
        bus.start = 1'b1; bus.clear = 1'b0; bus.byte_valid = 1'b0; bus.true_byte = 1'b1;
    endtask

    // Feed cnt consecutive bytes; bit i of mis marks byte i as a mismatch.
    task automatic feed(input int cnt, input logic [31:0] mis);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 1'b1, ~mis[i]);
        idle();
    endtask

    task automatic step2(input logic s, input logic v, input logic t);
        @(negedge clk);
        bus2.start = s; bus2.byte_valid = v; bus2.true_byte = t;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1;
        bus.start = 0; bus.clear = 0; bus.byte_valid = 0; bus.true_byte = 1; bus.n = 0; bus.max_err = 0;
        bus2.start = 0; bus2.clear = 0; bus2.byte_valid = 0; bus2.true_byte = 1; bus2.n = 0; bus2.max_err = 0;
        repeat (2) @(negedge clk);
        chk("rst_enable", 32'(bus.enable), 1);
        chk("rst_busy",   32'(bus.busy),   0);
        chk("rst_err",    32'(bus.err_count), 0);
        rst = 1'b0;

        // 1: strict pass
        do_start(8'd2, 8'd0);
        feed(8, 32'h0);
        chk("t1_valid", 32'(bus.pattern_valid), 1);
        chk("t1_enable", 32'(bus.enable), 0);
        chk("t1_busy", 32'(bus.busy), 0);
        chk("t1_byte", 32'(bus.byte_num), 3);
        chk("t1_seq", 32'(bus.seq_num), 1);
        chk("t1_err", 32'(bus.err_count), 0);

        // 2: strict fail on 3rd byte, later bytes ignored
        do_start(8'd2, 8'd0);
        feed(3, 32'h4);
        chk("t2_fail", 32'(bus.pattern_fail), 1);
        chk("t2_err", 32'(bus.err_count), 1);
        chk("t2_byte", 32'(bus.byte_num), 2);
        chk("t2_seq", 32'(bus.seq_num), 0);
        feed(3, 32'h0);
        chk("t2_hold_byte", 32'(bus.byte_num), 2);
        chk("t2_hold_fail", 32'(bus.pattern_fail), 1);

        // 3: tolerance 2
        do_start(8'd2, 8'd2);
        feed(8, 32'h11);
        chk("t3_valid", 32'(bus.pattern_valid), 1);
        chk("t3_err", 32'(bus.err_count), 2);
        do_start(8'd2, 8'd2);
        feed(8, 32'h51);
        chk("t3b_fail", 32'(bus.pattern_fail), 1);
        chk("t3b_err", 32'(bus.err_count), 3);
        chk("t3b_byte", 32'(bus.byte_num), 2);
        chk("t3b_seq", 32'(bus.seq_num), 1);

        // 4: gaps, restart from SUCCESS, n==0 ignored
        do_start(8'd2, 8'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("t4_valid", 32'(bus.pattern_valid), 1);
        do_start(8'd2, 8'd0);
        idle();
        chk("t4_restart_busy", 32'(bus.busy), 1);
        chk("t4_restart_byte", 32'(bus.byte_num), 0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        do_start(8'd0, 8'd0);
        idle();
        chk("t4_n0_busy", 32'(bus.busy), 0);
        chk("t4_n0_enable", 32'(bus.enable), 1);

        // 5: clear mid-check, start+clear from FAIL, async reset
        do_start(8'd2, 8'd0);
        feed(2, 32'h0);
        chk("t5_byte2", 32'(bus.byte_num), 2);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        chk("t5_clr_busy", 32'(bus.busy), 0);
        chk("t5_clr_byte", 32'(bus.byte_num), 0);
        chk("t5_clr_enable", 32'(bus.enable), 1);
        do_start(8'd2, 8'd0);
        feed(1, 32'h1);
        chk("t5_in_fail", 32'(bus.pattern_fail), 1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        chk("t5_sc_fail", 32'(bus.pattern_fail), 0);
        chk("t5_sc_busy", 32'(bus.busy), 0);
        do_start(8'd2, 8'd0);
        feed(3, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(bus.busy), 0);
        chk("t5_rst_byte", 32'(bus.byte_num), 0);
        chk("t5_rst_enable", 32'(bus.enable), 1);
        @(negedge clk);
        rst = 1'b0;

        // 6: narrow error counter, unlimited tolerance saturates
        @(negedge clk);
        bus2.n = 8'd2; bus2.max_err = 2'd3;
        step2(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step2(1'b0, 1'b1, 1'b0);
        step2(1'b0, 1'b0, 1'b1);
        chk("t6_valid", 32'(bus2.pattern_valid), 1);
        chk("t6_fail", 32'(bus2.pattern_fail), 0);
        chk("t6_err", 32'(bus2.err_count), 3);

        idle();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
